// File: rtl/cnt_pkg.sv
// rtl/cnt_pkg.sv - shared mode encoding and direction constants for the up/down bounce counter
package cnt_pkg;

  typedef enum logic [1:0] {
    CNT_UP     = 2'b00,
    CNT_DOWN   = 2'b01,
    CNT_BOUNCE = 2'b10,
    CNT_HOLD   = 2'b11
  } cnt_mode_e;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/cnt_dwell_timer.sv
// rtl/cnt_dwell_timer.sv - endpoint dwell down-counter, only built with CNT_DWELL_EN
`ifdef CNT_DWELL_EN
module cnt_dwell_timer #(
  parameter int DWELL = 2
) (
  input  logic CP,
  input  logic CLEAR_N,
  input  logic clr,
  input  logic start,
  input  logic tick,
  output logic busy,
  output logic done
);

  localparam int CW = (DWELL > 0) ? $clog2(DWELL + 1) : 1;
  localparam logic [CW-1:0] LOAD_CNT = CW'(DWELL);

  logic [CW-1:0] cnt;

  always_ff @(posedge CP or negedge CLEAR_N) begin
    if (!CLEAR_N) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (start) begin
      cnt <= LOAD_CNT;
    end else if (tick && busy) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign busy = (cnt != '0);
  // last held cycle; the following enabled step executes
  assign done = (cnt == CW'(1)) && tick;

endmodule
`endif

// File: rtl/updown_bounce_counter.sv
// rtl/updown_bounce_counter.sv - parametrised up/down-wrap/bounce counter; endpoint dwell enabled by CNT_DWELL_EN
module updown_bounce_counter
  import cnt_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DWELL = 2
) (
  input  logic             CP,
  input  logic             CLEAR_N,
  input  logic             EN,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] LOAD_VAL,
  input  logic [WIDTH-1:0] LO,
  input  logic [WIDTH-1:0] HI,
  input  logic [1:0]       MODE,
  output logic [WIDTH-1:0] out,
  output logic             DIR,
  output logic             WRAP
);

  cnt_mode_e        mode;
  logic [WIDTH-1:0] lo_p1;
  logic [WIDTH-1:0] step_out;
  logic [WIDTH-1:0] nxt_out;
  logic             step_dir;
  logic             step_evt;
  logic             nxt_dir;
  logic             nxt_wrap;
  logic             in_range;
  logic             dwell_hold;

  assign mode     = cnt_mode_e'(MODE);
  assign lo_p1    = LO + 1'b1;
  assign in_range = (out >= LO) && (out <= HI);

  if (WIDTH < 2) begin : g_bad_width
    $error("updown_bounce_counter: WIDTH must be at least 2");
  end

  // in-range step for the current mode, before any endpoint dwell
  always_comb begin
    step_out = out;
    step_dir = DIR;
    step_evt = 1'b0;
    case (mode)
      CNT_UP: begin
        step_dir = DIR_UP;
        if (out == HI) begin
          step_out = LO;
          step_evt = 1'b1;
        end else begin
          step_out = out + 1'b1;
        end
      end
      CNT_DOWN: begin
        step_dir = DIR_DOWN;
        if (out == LO) begin
          step_out = HI;
          step_evt = 1'b1;
        end else begin
          step_out = out - 1'b1;
        end
      end
      CNT_BOUNCE: begin
        if (DIR == DIR_UP) begin
          if (out == HI) begin
            step_out = HI - 1'b1;
            step_dir = DIR_DOWN;
            step_evt = 1'b1;
          end else begin
            step_out = out + 1'b1;
          end
        end else if (out > lo_p1) begin
          step_out = out - 1'b1;
        end else if (out == lo_p1) begin
          step_out = LO;
          step_dir = DIR_UP;
          step_evt = 1'b1;
        end else begin
          // descending while already at LO (entered from down-wrap): turn upward
          step_out = lo_p1;
          step_dir = DIR_UP;
          step_evt = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    nxt_out  = out;
    nxt_dir  = DIR;
    nxt_wrap = 1'b0;
    if (LOAD) begin
      nxt_out = LOAD_VAL;
      nxt_dir = (mode == CNT_DOWN) ? DIR_DOWN : DIR_UP;
    end else if (EN) begin
      if (LO >= HI) begin
        nxt_out = LO;
        nxt_dir = DIR_UP;
      end else if (!in_range) begin
        case (mode)
          CNT_UP, CNT_BOUNCE: begin
            nxt_out = LO;
            nxt_dir = DIR_UP;
          end
          CNT_DOWN: begin
            nxt_out = HI;
            nxt_dir = DIR_DOWN;
          end
          default: ;
        endcase
      end else if (mode != CNT_HOLD && !dwell_hold) begin
        nxt_out  = step_out;
        nxt_dir  = step_dir;
        nxt_wrap = step_evt;
      end
    end
  end

`ifdef CNT_DWELL_EN
  logic moving;
  logic dwell_clr;
  logic dwell_start;
  logic dwell_busy;
  logic dwell_done;

  assign moving      = EN && !LOAD && (LO < HI) && in_range && (mode != CNT_HOLD);
  assign dwell_clr   = LOAD || (EN && ((LO >= HI) || !in_range));
  // landing on an endpoint arms the dwell; the departing step waits for it
  assign dwell_start = moving && !dwell_busy && ((step_out == LO) || (step_out == HI));
  assign dwell_hold  = dwell_busy;

  cnt_dwell_timer #(.DWELL(DWELL)) u_dwell (
    .CP      (CP),
    .CLEAR_N (CLEAR_N),
    .clr     (dwell_clr),
    .start   (dwell_start),
    .tick    (moving),
    .busy    (dwell_busy),
    .done    (dwell_done)
  );
`else
  assign dwell_hold = 1'b0;

  if (DWELL < 0) begin : g_bad_dwell
    $error("updown_bounce_counter: DWELL must be non-negative");
  end
`endif

  always_ff @(posedge CP or negedge CLEAR_N) begin
    if (!CLEAR_N) begin
      out  <= '0;
      DIR  <= DIR_UP;
      WRAP <= 1'b0;
    end else begin
      out  <= nxt_out;
      DIR  <= nxt_dir;
      WRAP <= nxt_wrap;
    end
  end

endmodule

// File: tb/tb_updown_bounce_counter.sv
// tb/tb_updown_bounce_counter.sv - scoreboard bench for updown_bounce_counter (default build)
module tb_updown_bounce_counter;

  localparam int W = 4;

  logic         CP = 1'b0;
  logic         CLEAR_N;
  logic         EN;
  logic         LOAD;
  logic [W-1:0] LOAD_VAL;
  logic [W-1:0] LO;
  logic [W-1:0] HI;
  logic [1:0]   MODE;
  logic [W-1:0] out;
  logic         DIR;
  logic         WRAP;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic         en;
    logic         ld;
    logic [W-1:0] lv;
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    logic [1:0]   md;
    logic [W-1:0] o;
    logic         d;
    logic         w;
  } row_t;

  typedef struct {
    logic [W-1:0] o;
    logic         d;
    logic         w;
  } exp_t;

  exp_t sb[$];

  updown_bounce_counter #(.WIDTH(W)) dut (
    .CP       (CP),
    .CLEAR_N  (CLEAR_N),
    .EN       (EN),
    .LOAD     (LOAD),
    .LOAD_VAL (LOAD_VAL),
    .LO       (LO),
    .HI       (HI),
    .MODE     (MODE),
    .out      (out),
    .DIR      (DIR),
    .WRAP     (WRAP)
  );

  always #5 CP = ~CP;

  function automatic row_t mk(input logic en, input logic ld, input int lv, input int lo, input int hi,
                              input logic [1:0] md, input int o, input logic d, input logic w);
    row_t r;
    r.en = en; r.ld = ld; r.lv = W'(lv); r.lo = W'(lo); r.hi = W'(hi); r.md = md;
    r.o = W'(o); r.d = d; r.w = w;
    return r;
  endfunction

  task automatic drive(input row_t r);
    exp_t e;
    EN = r.en; LOAD = r.ld; LOAD_VAL = r.lv; LO = r.lo; HI = r.hi; MODE = r.md;
    e.o = r.o; e.d = r.d; e.w = r.w;
    sb.push_back(e);
  endtask

  task automatic test_reset();
    CLEAR_N = 1'b0; EN = 1'b1; LOAD = 1'b0; LOAD_VAL = '0; LO = '0; HI = 4'd15; MODE = 2'b10;
    repeat (2) @(posedge CP);
    #1;
    total++; if (out !== 4'd0) begin bad++; $display("FAIL reset_out: got %0d want 0", out); end
    total++; if (DIR !== 1'b0) begin bad++; $display("FAIL reset_dir: got %b want 0", DIR); end
    total++; if (WRAP !== 1'b0) begin bad++; $display("FAIL reset_wrap: got %b want 0", WRAP); end
    CLEAR_N = 1'b1;
  endtask

  task automatic test_bounce();
    row_t q[$];
    exp_t e;
    for (int i = 1; i <= 15; i++) q.push_back(mk(1, 0, 0, 0, 15, 2'b10, i, 0, 0));
    q.push_back(mk(1, 0, 0, 0, 15, 2'b10, 14, 1, 1));
    for (int i = 13; i >= 1; i--) q.push_back(mk(1, 0, 0, 0, 15, 2'b10, i, 1, 0));
    q.push_back(mk(1, 0, 0, 0, 15, 2'b10, 0, 0, 1));
    q.push_back(mk(1, 0, 0, 0, 15, 2'b10, 1, 0, 0));
    foreach (q[i]) begin
      drive(q[i]);
      @(posedge CP); #1;
      e = sb.pop_front();
      total++;
      if (out !== e.o || DIR !== e.d || WRAP !== e.w) begin
        bad++;
        $display("FAIL bounce[%0d]: out=%0d dir=%b wrap=%b want out=%0d dir=%b wrap=%b", i, out, DIR, WRAP, e.o, e.d, e.w);
      end
    end
  endtask

  task automatic test_upwrap_downwrap();
    row_t q[$];
    exp_t e;
    q.push_back(mk(1, 0, 0, 3, 6, 2'b00, 3, 0, 0));
    q.push_back(mk(1, 0, 0, 3, 6, 2'b00, 4, 0, 0));
    q.push_back(mk(1, 0, 0, 3, 6, 2'b00, 5, 0, 0));
    q.push_back(mk(1, 0, 0, 3, 6, 2'b00, 6, 0, 0));
    q.push_back(mk(1, 0, 0, 3, 6, 2'b00, 3, 0, 1));
    q.push_back(mk(1, 0, 0, 3, 6, 2'b00, 4, 0, 0));
    q.push_back(mk(1, 0, 0, 3, 6, 2'b00, 5, 0, 0));
    q.push_back(mk(1, 0, 0, 3, 6, 2'b01, 4, 1, 0));
    q.push_back(mk(1, 0, 0, 3, 6, 2'b01, 3, 1, 0));
    q.push_back(mk(1, 0, 0, 3, 6, 2'b01, 6, 1, 1));
    foreach (q[i]) begin
      drive(q[i]);
      @(posedge CP); #1;
      e = sb.pop_front();
      total++;
      if (out !== e.o || DIR !== e.d || WRAP !== e.w) begin
        bad++;
        $display("FAIL updown[%0d]: out=%0d dir=%b wrap=%b want out=%0d dir=%b wrap=%b", i, out, DIR, WRAP, e.o, e.d, e.w);
      end
    end
  endtask

  task automatic test_load_clamp();
    row_t q[$];
    exp_t e;
    q.push_back(mk(0, 1, 12, 2, 8, 2'b10, 12, 0, 0));
    q.push_back(mk(1, 0, 0, 2, 8, 2'b10, 2, 0, 0));
    q.push_back(mk(1, 0, 0, 2, 8, 2'b10, 3, 0, 0));
    q.push_back(mk(0, 0, 0, 2, 8, 2'b10, 3, 0, 0));
    foreach (q[i]) begin
      drive(q[i]);
      @(posedge CP); #1;
      e = sb.pop_front();
      total++;
      if (out !== e.o || DIR !== e.d || WRAP !== e.w) begin
        bad++;
        $display("FAIL load[%0d]: out=%0d dir=%b wrap=%b want out=%0d dir=%b wrap=%b", i, out, DIR, WRAP, e.o, e.d, e.w);
      end
    end
  endtask

  task automatic test_async_reset();
    row_t q[$];
    exp_t e;
    q.push_back(mk(0, 1, 9, 0, 15, 2'b01, 9, 1, 0));
    foreach (q[i]) begin
      drive(q[i]);
      @(posedge CP); #1;
      e = sb.pop_front();
      total++;
      if (out !== e.o || DIR !== e.d || WRAP !== e.w) begin
        bad++;
        $display("FAIL async_pre[%0d]: out=%0d dir=%b wrap=%b want out=%0d dir=%b wrap=%b", i, out, DIR, WRAP, e.o, e.d, e.w);
      end
    end
    #2 CLEAR_N = 1'b0;
    #1;
    total++;
    if (out !== 4'd0 || DIR !== 1'b0 || WRAP !== 1'b0) begin
      bad++;
      $display("FAIL async_reset: out=%0d dir=%b wrap=%b want out=0 dir=0 wrap=0", out, DIR, WRAP);
    end
    @(posedge CP); #1;
    CLEAR_N = 1'b1;
    q.delete();
    q.push_back(mk(0, 0, 0, 0, 15, 2'b00, 0, 0, 0));
    q.push_back(mk(0, 0, 0, 0, 15, 2'b00, 0, 0, 0));
    q.push_back(mk(1, 0, 0, 0, 15, 2'b00, 1, 0, 0));
    foreach (q[i]) begin
      drive(q[i]);
      @(posedge CP); #1;
      e = sb.pop_front();
      total++;
      if (out !== e.o || DIR !== e.d || WRAP !== e.w) begin
        bad++;
        $display("FAIL async_post[%0d]: out=%0d dir=%b wrap=%b want out=%0d dir=%b wrap=%b", i, out, DIR, WRAP, e.o, e.d, e.w);
      end
    end
  endtask

  task automatic test_degenerate_priority();
    row_t q[$];
    exp_t e;
    for (int m = 0; m < 4; m++) q.push_back(mk(1, 0, 0, 5, 5, 2'(m), 5, 0, 0));
    q.push_back(mk(1, 0, 0, 7, 4, 2'b10, 7, 0, 0));
    q.push_back(mk(1, 0, 0, 7, 4, 2'b00, 7, 0, 0));
    q.push_back(mk(1, 1, 10, 0, 15, 2'b00, 10, 0, 0));
    q.push_back(mk(1, 1, 2, 0, 15, 2'b01, 2, 1, 0));
    q.push_back(mk(1, 0, 0, 0, 15, 2'b01, 1, 1, 0));
    q.push_back(mk(1, 0, 0, 0, 15, 2'b01, 0, 1, 0));
    q.push_back(mk(1, 0, 0, 0, 15, 2'b01, 15, 1, 1));
    q.push_back(mk(1, 0, 0, 0, 15, 2'b01, 14, 1, 0));
    q.push_back(mk(1, 0, 0, 0, 15, 2'b11, 14, 1, 0));
    q.push_back(mk(1, 0, 0, 0, 15, 2'b11, 14, 1, 0));
    q.push_back(mk(1, 0, 0, 0, 15, 2'b10, 13, 1, 0));
    q.push_back(mk(1, 0, 0, 0, 15, 2'b00, 14, 0, 0));
    q.push_back(mk(1, 0, 0, 0, 15, 2'b00, 15, 0, 0));
    q.push_back(mk(1, 0, 0, 0, 15, 2'b00, 0, 0, 1));
    foreach (q[i]) begin
      drive(q[i]);
      @(posedge CP); #1;
      e = sb.pop_front();
      total++;
      if (out !== e.o || DIR !== e.d || WRAP !== e.w) begin
        bad++;
        $display("FAIL degen_prio[%0d]: out=%0d dir=%b wrap=%b want out=%0d dir=%b wrap=%b", i, out, DIR, WRAP, e.o, e.d, e.w);
      end
    end
  endtask

  initial begin
    test_reset();
    test_bounce();
    test_upwrap_downwrap();
    test_load_clamp();
    test_async_reset();
    test_degenerate_priority();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
